csa_accum: RTL
==============

CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 Parameter IN_W, default 24, sets the width of one unsigned operand lane.
REQ-002 Parameter ACC_W, default 32, sets the accumulator width and SHALL satisfy ACC_W >= IN_W.
REQ-003 Parameter LANES, default 2, sets the operands per beat and SHALL satisfy 1 <= LANES <= 8.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block accepts a beat.
REQ-009 in_data  in  LANES*IN_W  lane k at bits [k*IN_W +: IN_W], each zero-extended to ACC_W.
REQ-010 in_last  in  1  final beat of the packet.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_data  out  ACC_W  packet sum mod 2^ACC_W.
REQ-014 out_count  out  16  beats in the packet (see REQ-027).

Function
REQ-015 A beat SHALL transfer when in_valid and in_ready are both high at a rising clk edge; a result SHALL transfer when out_valid and out_ready are both high.
REQ-016 The FSM SHALL have states ACC, RESOLVE and HOLD, and SHALL hold in_ready = (state==ACC) and out_valid = (state==HOLD).
REQ-017 The state SHALL be held as two ACC_W vectors, S and C; each accepted beat SHALL reduce {S, C, lane0..laneLANES-1} to a new {S, C} through a chain of LANES 3:2 carry-save stages in one cycle.
REQ-018 Each stage's carry vector SHALL be shifted left one bit with bit0 = 0, and the carry out of bit ACC_W-1 SHALL be dropped (modulo arithmetic, no overflow flag).
REQ-019 Transitions SHALL be: ACC -> RESOLVE on an accepted beat with in_last = 1; RESOLVE -> HOLD unconditionally; HOLD -> ACC on a result transfer.
REQ-020 In RESOLVE, out_data SHALL be registered as (S + C) mod 2^ACC_W, and S and C SHALL be cleared to 0.
REQ-021 Latency SHALL be: last beat accepted at edge t gives out_valid = 1 after edge t+1, and in_ready = 1 again the cycle after the result transfer.
REQ-022 In ACC with in_valid low, S and C SHALL hold (gaps allowed); out_ready SHALL be ignored outside HOLD.
REQ-023 In HOLD, out_data and out_count SHALL stay stable until the transfer, with no input accepted (back-pressure).
REQ-024 in_data and in_last SHALL be ignored when no beat transfers.

Reset
REQ-025 When rst_n is low, the block SHALL set state = ACC, S = C = 0, out_data = 0, out_count = 0, out_valid = 0 and in_ready = 1, immediately and independent of clk.
REQ-026 Reset mid-packet or in HOLD SHALL discard partial sums and any pending result; no partial result SHALL be emitted.

Configuration
REQ-027 With CSA_ACCUM_COUNT_EN defined, a 16-bit beat counter SHALL increment per accepted beat, saturate at 0xFFFF, be latched to out_count in RESOLVE, and clear with S and C.
REQ-028 Without CSA_ACCUM_COUNT_EN, no counter SHALL be built and out_count SHALL be constant 0.

Structure
REQ-029 Package csa_pkg SHALL hold the state enum (ACC, RESOLVE, HOLD), the default widths, and the CNT_W = 16 constant.
REQ-030 One sub-module csa_3to2 (parameter W; ports a, b, c, s, cout, all W bits, with cout already shifted and cout[0] = 0) SHALL be instantiated LANES times.

Verification
REQ-031 Reset: rst_n low -> in_ready = 1, out_valid = 0, out_data = 0, out_count = 0.
REQ-032 Single beat: lanes {0x000003, 0x000005}, last = 1 -> out_valid two edges later, out_data = 0x00000008, out_count = 1 (macro on).
REQ-033 Three beats, all lanes 0xFFFFFF, third beat last, with one idle cycle between beats 1 and 2 -> out_data = 0x05FFFFFA, out_count = 3.
REQ-034 Wrap: ACC_W = 26, four beats of all lanes 0xFFFFFF -> out_data = 0x3FFFFF8.
REQ-035 Back-pressure: out_ready low for 5 cycles in HOLD -> out_data stable and in_ready = 0; on transfer, in_ready = 1 the next cycle.
REQ-036 Reset mid-packet: two beats of 0x100 lanes, then rst_n pulse, then lanes {1, 1} last -> out_data = 2, out_count = 1.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save packet accumulator:
// FSM state encoding, default widths and the beat-counter width.
package csa_pkg;

   localparam int IN_W_DEF  = 24;
   localparam int ACC_W_DEF = 32;
   localparam int LANES_DEF = 2;
   localparam int CNT_W     = 16;

   typedef enum logic [1:0] {
      ACC     = 2'd0,
      RESOLVE = 2'd1,
      HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/csa_3to2.sv
// One 3:2 carry-save compressor stage of width W.
// The carry vector comes out already weighted (shifted left one bit,
// bit 0 forced to 0); the carry out of the top bit is discarded, which
// gives modulo-2^W behaviour.
module csa_3to2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] cout
);

   logic [W-1:0] maj;

   assign s    = a ^ b ^ c;
   assign maj  = (a & b) | (a & c) | (b & c);
   // Shift drops maj[W-1] and inserts a zero at bit 0.
   assign cout = maj << 1;

endmodule

// File: rtl/csa_accum.sv
// Packet accumulator: sums LANES unsigned lanes per beat into a
// redundant (sum, carry) pair using a chain of 3:2 compressors, then
// resolves the pair with a single carry-propagate add after the last beat.
// Optional build macro: CSA_ACCUM_COUNT_EN adds a saturating 16-bit beat
// counter reported on out_count; without it out_count is tied to 0.
module csa_accum
   import csa_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int LANES = LANES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*IN_W-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic [CNT_W-1:0]      out_count
);

   state_t state_reg, state_next;

   logic [ACC_W-1:0] s_reg, c_reg, out_data_reg;
   logic [ACC_W-1:0] s_chain  [LANES+1];
   logic [ACC_W-1:0] c_chain  [LANES+1];
   logic [ACC_W-1:0] lane_ext [LANES];
   logic             beat;

   assign in_ready  = (state_reg == ACC);
   assign out_valid = (state_reg == HOLD);
   assign out_data  = out_data_reg;
   assign beat      = in_valid && in_ready;

   // Compressor chain: stage k folds lane k into the running (s, c) pair.
   assign s_chain[0] = s_reg;
   assign c_chain[0] = c_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_stage
         assign lane_ext[gi] = ACC_W'(in_data[gi*IN_W +: IN_W]);
         csa_3to2 #(.W(ACC_W)) u_csa (
            .a    (s_chain[gi]),
            .b    (c_chain[gi]),
            .c    (lane_ext[gi]),
            .s    (s_chain[gi+1]),
            .cout (c_chain[gi+1])
         );
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ACC;
      else        state_reg <= state_next;
   end

   // Next-state: accumulate until the last beat, resolve once, hold for the consumer.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACC:     if (beat && in_last) state_next = RESOLVE;
         RESOLVE: state_next = HOLD;
         HOLD:    if (out_ready) state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   // Redundant accumulator and result register; resolve clears the pair for the next packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg        <= '0;
         c_reg        <= '0;
         out_data_reg <= '0;
      end else if (state_reg == RESOLVE) begin
         out_data_reg <= s_reg + c_reg;
         s_reg        <= '0;
         c_reg        <= '0;
      end else if (beat) begin
         s_reg <= s_chain[LANES];
         c_reg <= c_chain[LANES];
      end
   end

`ifdef CSA_ACCUM_COUNT_EN
   logic [CNT_W-1:0] cnt_reg, out_count_reg;

   // Saturating beat counter, snapshotted alongside the resolved sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         out_count_reg <= '0;
      end else if (state_reg == RESOLVE) begin
         out_count_reg <= cnt_reg;
         cnt_reg       <= '0;
      end else if (beat && (cnt_reg != '1)) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign out_count = out_count_reg;
`else
   assign out_count = '0;
`endif

endmodule
